alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Decode/operand-fetch stage sitting directly upstream of the registered ALU.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them.
- Reads a 16x32 register file, forwards results and detects hazards, then drives the ALU's a, b and op inputs.
- Owns the register file and commits the ALU result back to the destination register two cycles after issue.

Parameters:
- DATA_W, 32, operand/result width
- NREGS, 16, architectural register count; index width is clog2(NREGS)=4
- OP_W, 8, ALU opcode width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  instruction word present
- in_instr_i  in  32  instruction word
- in_ready_o  out  1  stage can accept (combinational)
- alu_a_o  out  DATA_W  ALU operand a (registered)
- alu_b_o  out  DATA_W  ALU operand b (registered)
- alu_op_o  out  OP_W  ALU opcode (registered)
- alu_valid_o  out  1  a/b/op carry a live instruction this cycle
- alu_result_i  in  DATA_W  ALU out, valid two cycles after issue
- illegal_o  out  1  one-cycle pulse: illegal opcode consumed
- dbg_addr_i  in  4  debug register index
- dbg_data_o  out  DATA_W  combinational register-file read for verification

Behaviour:
- Instruction format:
  - [31:24] op, [23:20] rd, [19:16] rs1, [15] use_imm.
  - [14:11] rs2 when use_imm=0.
  - b = zero-extended [14:0] when use_imm=1.
- Legal ops: 01 LD, 03 ADD, 04 SUB, 05 AND, 06 OR, 07 XOR, 08 NOT, 09 SL, 0A SR. Every other value, including 00 and 02, is illegal.
- r0 reads as 0. Writes to r0 are discarded and never create hazards.
- Reset (async, rst_n=0):
  - All registers, register file, alu_a_o, alu_b_o, alu_op_o, alu_valid_o, illegal_o and pipeline tags go to 0.
  - in_ready_o=0 while rst_n=0.
  - In-flight writebacks are lost.
- Handshake: transfer occurs on an edge where in_valid_i && in_ready_o. in_instr_i must stay stable while in_valid_i=1 and in_ready_o=0.
- Issue at edge E0:
  - alu_a_o, alu_b_o, alu_op_o and alu_valid_o=1 are registered.
  - Tag s1 = {valid, rd} is set.
- E1: the ALU registers its output. Tag s1 moves to s2.
- E2: alu_result_i is valid in the cycle before E2. regfile[s2.rd] <= alu_result_i when s2.valid and rd!=0.
- Issue-to-writeback latency: 2 cycles. Issue throughput: 1 instruction/cycle.
- Cycles with no transfer: alu_valid_o=0 and alu_op_o=00. a and b hold their last value.
- Operand source for rs1 and for rs2 (when used):
  - If it matches s2.rd (s2.valid, rd!=0), forward alu_result_i.
  - Otherwise read regfile. Forwarding takes priority over the same-cycle write.
- Hazard: a used source matches s1.rd (s1.valid, rd!=0).
  - in_ready_o=0 for exactly one cycle (one bubble).
  - The next cycle resolves via forwarding.
  - rs2 is ignored for hazard and forwarding when use_imm=1.
  - NOT (08) and LD (01) still read rs1 and rs2/imm normally; the decoder does not special-case them.
- Illegal op:
  - Consumed normally (in_ready_o unaffected by legality).
  - illegal_o=1 for the cycle after the transfer; alu_valid_o=0.
  - No s1 tag and no writeback.
- Simultaneous events: issue, ALU computation and writeback to three different instructions in the same cycle is the normal steady state. Issue whose rd equals s2.rd overwrites later in order (E2 then its own E2); no conflict.
- Reset mid-operation: state clears immediately; no partial writes after rst_n rises.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_LD=8'h01 … OP_SR=8'h0A, OP_NOP=8'h00
  - function is_legal_op
  - instruction field offsets
  - DATA_W and NREGS defaults
- Sub-module alu_issue_regfile: 16x32, two async read ports plus debug read port, one sync write port, r0 forced to 0, async reset clear.
- Decode, hazard and forwarding logic stay in the top module.

Test Plan:
1. Reset then issue LD r1, imm=0x7FFF (01_1_0_1_7FFF) with the ALU model returning b → alu_op_o=01, alu_b_o=0x7FFF on the cycle after issue; regfile[1]=0x7FFF two edges after issue; dbg_data_o(1)=0x7FFF.
2. Back-to-back dependency: LD r2,#5 then ADD r3,r2,r2 → in_ready_o low exactly one cycle; ADD issues with alu_a_o=alu_b_o=5 via forwarding; r3=10.
3. Independent stream: ADD r4,r1,#1; SUB r5,r1,#2; XOR r6,r1,#3 → one issue per cycle, in_ready_o never drops, r4/r5/r6 = 0x8000/0x7FFD/0x7FFC.
4. Illegal op 0x02 then op 0xFF → each consumed; illegal_o pulses once per instruction; alu_valid_o=0; no register changes.
5. r0 handling: LD r0,#0x1234 then ADD r7,r0,#1 → no stall; r0 stays 0; r7=1.
6. Reset asserted while an instruction sits in s1 → all outputs 0 within the reset assertion; destination register not written after rst_n release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, instruction field layout and decode helpers for the
// issue stage that feeds the registered ALU.
package alu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 16;
    localparam int DEF_OP_W   = 8;
    localparam int REG_W      = 4;
    localparam int INSTR_W    = 32;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LD  = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05;
    localparam logic [7:0] OP_OR  = 8'h06;
    localparam logic [7:0] OP_XOR = 8'h07;
    localparam logic [7:0] OP_NOT = 8'h08;
    localparam logic [7:0] OP_SL  = 8'h09;
    localparam logic [7:0] OP_SR  = 8'h0A;

    localparam int OP_LSB   = 24;
    localparam int RD_LSB   = 20;
    localparam int RS1_LSB  = 16;
    localparam int IMM_BIT  = 15;
    localparam int RS2_LSB  = 11;
    localparam int IMM_W    = 15;

    typedef struct packed {
        logic [7:0]       op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use_imm;
        logic [IMM_W-1:0] imm;
    } dec_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } tag_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        logic ok;
        case (op)
            OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SL, OP_SR: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic dec_t decode_instr(input logic [INSTR_W-1:0] w);
        dec_t d;
        d.op      = w[OP_LSB +: 8];
        d.rd      = w[RD_LSB +: REG_W];
        d.rs1     = w[RS1_LSB +: REG_W];
        d.rs2     = w[RS2_LSB +: REG_W];
        d.use_imm = w[IMM_BIT];
        d.imm     = w[IMM_W-1:0];
        return d;
    endfunction

    // A tag only blocks or forwards when it names a real (non-r0) destination.
    function automatic logic tag_hits(input tag_t t, input logic [REG_W-1:0] src);
        return t.valid && (t.rd != {REG_W{1'b0}}) && (t.rd == src);
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two async read ports, a debug read port and
// one synchronous write port; r0 is hardwired to zero.
module alu_issue_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_W-1:0]  raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [REG_W-1:0]  raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic [REG_W-1:0]  dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] mem_q [NREGS];

    function automatic logic [DATA_W-1:0] rd_port(input logic [REG_W-1:0] a,
                                                  input logic [DATA_W-1:0] v);
        return (a == {REG_W{1'b0}}) ? {DATA_W{1'b0}} : v;
    endfunction

    // Storage: cleared by reset, r0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we_i && (waddr_i != {REG_W{1'b0}})) begin
            mem_q[waddr_i] <= wdata_i;
        end else begin
            mem_q[0] <= {DATA_W{1'b0}};
        end
    end

    // Read ports.
    always_comb begin
        rdata1_o   = rd_port(raddr1_i, mem_q[raddr1_i]);
        rdata2_o   = rd_port(raddr2_i, mem_q[raddr2_i]);
        dbg_data_o = rd_port(dbg_addr_i, mem_q[dbg_addr_i]);
    end

endmodule

// File: rtl/alu_issue.sv
// Decode/operand-fetch stage: decodes instructions, resolves hazards by a
// single bubble or forwarding, drives the ALU and commits its result.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [31:0]       in_instr_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [OP_W-1:0]   alu_op_o,
    output logic              alu_valid_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              illegal_o,
    input  logic [REG_W-1:0]  dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    dec_t              dec_s;
    logic              legal_s;
    logic              hazard_s;
    logic              fire_s;
    logic              wb_en_s;
    logic [DATA_W-1:0] rf_rd1_s;
    logic [DATA_W-1:0] rf_rd2_s;
    logic [DATA_W-1:0] opa_s;
    logic [DATA_W-1:0] opb_s;

    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    logic [OP_W-1:0]   alu_op_q,    alu_op_d;
    logic              alu_valid_q, alu_valid_d;
    logic              illegal_q,   illegal_d;
    tag_t              s1_q,        s1_d;
    tag_t              s2_q,        s2_d;

    assign dec_s   = decode_instr(in_instr_i);
    assign legal_s = is_legal_op(dec_s.op);
    assign wb_en_s = s2_q.valid && (s2_q.rd != {REG_W{1'b0}});

    alu_issue_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (wb_en_s),
        .waddr_i    (s2_q.rd),
        .wdata_i    (alu_result_i),
        .raddr1_i   (dec_s.rs1),
        .rdata1_o   (rf_rd1_s),
        .raddr2_i   (dec_s.rs2),
        .rdata2_o   (rf_rd2_s),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o)
    );

    // Hazard against the instruction still inside the ALU; rs2 only counts when used.
    always_comb begin
        hazard_s = tag_hits(s1_q, dec_s.rs1);
        if (!dec_s.use_imm) begin
            hazard_s = hazard_s || tag_hits(s1_q, dec_s.rs2);
        end else begin
            hazard_s = hazard_s;
        end
        in_ready_o = rst_n && !(in_valid_i && hazard_s);
        fire_s     = in_valid_i && in_ready_o;
    end

    // Operand select: the result about to be written wins over the register file.
    always_comb begin
        if (tag_hits(s2_q, dec_s.rs1)) begin
            opa_s = alu_result_i;
        end else begin
            opa_s = rf_rd1_s;
        end
        if (dec_s.use_imm) begin
            opb_s = {{(DATA_W-IMM_W){1'b0}}, dec_s.imm};
        end else if (tag_hits(s2_q, dec_s.rs2)) begin
            opb_s = alu_result_i;
        end else begin
            opb_s = rf_rd2_s;
        end
    end

    // Issue decision and pipeline tag advance.
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = OP_W'(OP_NOP);
        alu_valid_d = 1'b0;
        illegal_d   = 1'b0;
        s1_d        = '0;
        s2_d        = s1_q;
        if (fire_s && legal_s) begin
            alu_a_d     = opa_s;
            alu_b_d     = opb_s;
            alu_op_d    = OP_W'(dec_s.op);
            alu_valid_d = 1'b1;
            s1_d.valid  = 1'b1;
            s1_d.rd     = dec_s.rd;
        end else if (fire_s) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = 1'b0;
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= {DATA_W{1'b0}};
            alu_b_q     <= {DATA_W{1'b0}};
            alu_op_q    <= {OP_W{1'b0}};
            alu_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_valid_q <= alu_valid_d;
            illegal_q   <= illegal_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign alu_valid_o = alu_valid_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Randomised and directed bench for alu_issue against an in-order
// architectural model of the instruction stream.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready_o;
    logic [31:0] alu_a_o, alu_b_o;
    logic [7:0]  alu_op_o;
    logic        alu_valid_o;
    logic [31:0] alu_res;
    logic        illegal_o;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_edge = -10;
    int last_rd   = 0;
    logic [31:0] model_rf [16];

    alu_issue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_instr_i   (in_instr),
        .in_ready_o   (in_ready_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_op_o     (alu_op_o),
        .alu_valid_o  (alu_valid_o),
        .alu_result_i (alu_res),
        .illegal_o    (illegal_o),
        .dbg_addr_i   (dbg_addr),
        .dbg_data_o   (dbg_data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_fn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            8'h01:   return b;
            8'h03:   return a + b;
            8'h04:   return a - b;
            8'h05:   return a & b;
            8'h06:   return a | b;
            8'h07:   return a ^ b;
            8'h08:   return ~a;
            8'h09:   return a << b[4:0];
            8'h0A:   return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    // The downstream registered ALU.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_res <= 32'h0;
        else        alu_res <= alu_fn(alu_op_o, alu_a_o, alu_b_o);
    end

    function automatic logic [31:0] mk_imm(input logic [7:0] op, input int rd, input int rs1, input logic [14:0] imm);
        return {op, 4'(rd), 4'(rs1), 1'b1, imm};
    endfunction

    function automatic logic [31:0] mk_reg(input logic [7:0] op, input int rd, input int rs1, input int rs2);
        return {op, 4'(rd), 4'(rs1), 1'b0, 4'(rs2), 11'h0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_rf[i] = 32'h0;
        last_rd   = 0;
        last_edge = -10;
    endtask

    // Present one instruction, wait out any stall and check the issued operands.
    task automatic issue(input logic [31:0] instr, output int stalls);
        logic [7:0]  op;
        int          rd, rs1, rs2, n;
        logic        ui, legal, exp_stall;
        logic [31:0] exp_a, exp_b;
        op  = instr[31:24];
        rd  = int'(instr[23:20]);
        rs1 = int'(instr[19:16]);
        ui  = instr[15];
        rs2 = int'(instr[14:11]);
        legal = (op == 8'h01) || (op >= 8'h03 && op <= 8'h0A);
        exp_a = model_rf[rs1];
        exp_b = ui ? {17'h0, instr[14:0]} : model_rf[rs2];
        @(negedge clk);
        exp_stall = (cyc == last_edge) && (last_rd != 0) &&
                    (rs1 == last_rd || (!ui && rs2 == last_rd));
        in_valid = 1'b1;
        in_instr = instr;
        #1;
        n = 0;
        while (!in_ready_o && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout: in_ready=%b required 1 (instr %h)", in_ready_o, instr);
        end
        total++;
        if (n !== int'(exp_stall)) begin
            bad++;
            $display("FAIL stall_count: got %0d required %0d (instr %h)", n, exp_stall, instr);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (legal) begin
            total++;
            if ({alu_valid_o, illegal_o, alu_op_o} !== {1'b1, 1'b0, op}) begin
                bad++;
                $display("FAIL issue_ctrl: valid/illegal/op=%b/%b/%h required 1/0/%h", alu_valid_o, illegal_o, alu_op_o, op);
            end
            total++;
            if (alu_a_o !== exp_a || alu_b_o !== exp_b) begin
                bad++;
                $display("FAIL issue_operands: a=%h b=%h required a=%h b=%h (instr %h)", alu_a_o, alu_b_o, exp_a, exp_b, instr);
            end
            if (rd != 0) model_rf[rd] = alu_fn(op, exp_a, exp_b);
            last_rd = rd;
        end else begin
            total++;
            if ({alu_valid_o, illegal_o, alu_op_o} !== {1'b0, 1'b1, 8'h00}) begin
                bad++;
                $display("FAIL illegal_ctrl: valid/illegal/op=%b/%b/%h required 0/1/00", alu_valid_o, illegal_o, alu_op_o);
            end
            last_rd = 0;
        end
        last_edge = cyc;
        stalls = n;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_regs();
        idle(3);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            total++;
            if (dbg_data_o !== model_rf[i]) begin
                bad++;
                $display("FAIL regfile_r%0d: got %h required %h", i, dbg_data_o, model_rf[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; dbg_addr = 4'd0;
        model_reset();
        #12;
        total++;
        if ({in_ready_o, alu_valid_o, illegal_o, alu_op_o, alu_a_o, alu_b_o} !== 75'h0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b valid=%b ill=%b op=%h a=%h b=%h required all 0",
                     in_ready_o, alu_valid_o, illegal_o, alu_op_o, alu_a_o, alu_b_o);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b required 1", in_ready_o);
        end
        check_regs();
    endtask

    task automatic test_ld();
        int s;
        dbg_addr = 4'd1;
        issue(mk_imm(8'h01, 1, 0, 15'h7FFF), s);
        total++;
        if (alu_op_o !== 8'h01 || alu_b_o !== 32'h7FFF || dbg_data_o !== 32'h0) begin
            bad++;
            $display("FAIL ld_issue: op=%h b=%h r1=%h required 01/00007fff/0", alu_op_o, alu_b_o, dbg_data_o);
        end
        @(posedge clk); #1;
        total++;
        if (dbg_data_o !== 32'h0) begin
            bad++;
            $display("FAIL ld_early_write: r1=%h required 0 one edge after issue", dbg_data_o);
        end
        @(posedge clk); #1;
        total++;
        if (dbg_data_o !== 32'h7FFF) begin
            bad++;
            $display("FAIL ld_writeback: r1=%h required 00007fff two edges after issue", dbg_data_o);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        issue(mk_imm(8'h01, 2, 0, 15'd5), s);
        issue(mk_reg(8'h03, 3, 2, 2), s);
        total++;
        if (s !== 1 || alu_a_o !== 32'd5 || alu_b_o !== 32'd5) begin
            bad++;
            $display("FAIL b2b_forward: stalls=%0d a=%h b=%h required 1/5/5", s, alu_a_o, alu_b_o);
        end
        check_regs();
        dbg_addr = 4'd3; #1;
        total++;
        if (dbg_data_o !== 32'd10) begin
            bad++;
            $display("FAIL b2b_r3: got %h required 0000000a", dbg_data_o);
        end
    endtask

    task automatic test_independent();
        int s, sum;
        sum = 0;
        issue(mk_imm(8'h03, 4, 1, 15'd1), s); sum += s;
        issue(mk_imm(8'h04, 5, 1, 15'd2), s); sum += s;
        issue(mk_imm(8'h07, 6, 1, 15'd3), s); sum += s;
        total++;
        if (sum !== 0) begin
            bad++;
            $display("FAIL indep_stalls: got %0d required 0", sum);
        end
        check_regs();
        total++;
        if (model_rf[4] !== 32'h8000 || model_rf[5] !== 32'h7FFD || model_rf[6] !== 32'h7FFC) begin
            bad++;
            $display("FAIL indep_values: model r4/r5/r6=%h/%h/%h required 8000/7ffd/7ffc", model_rf[4], model_rf[5], model_rf[6]);
        end
    endtask

    task automatic test_illegal();
        int s;
        issue(mk_imm(8'h02, 8, 1, 15'd9), s);
        issue(mk_reg(8'hFF, 9, 1, 2), s);
        idle(1);
        total++;
        if (illegal_o !== 1'b0 || alu_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pulse_end: ill=%b valid=%b required 0/0", illegal_o, alu_valid_o);
        end
        check_regs();
    endtask

    task automatic test_r0();
        int s;
        issue(mk_imm(8'h01, 0, 0, 15'h1234), s);
        issue(mk_imm(8'h03, 7, 0, 15'd1), s);
        total++;
        if (s !== 0) begin
            bad++;
            $display("FAIL r0_no_stall: stalls=%0d required 0", s);
        end
        check_regs();
        dbg_addr = 4'd7; #1;
        total++;
        if (dbg_data_o !== 32'd1) begin
            bad++;
            $display("FAIL r0_r7: got %h required 00000001", dbg_data_o);
        end
    endtask

    task automatic test_random();
        int s;
        logic [7:0] ops [13];
        logic [7:0] op;
        ops = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                8'h00, 8'h02, 8'h0B, 8'hFF};
        for (int k = 0; k < 300; k++) begin
            op = ($urandom_range(0, 9) == 0) ? ops[$urandom_range(9, 12)] : ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1)
                issue(mk_imm(op, $urandom_range(0, 7), $urandom_range(0, 7), 15'($urandom)), s);
            else
                issue({op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 1'b0,
                       4'($urandom_range(0, 7)), 11'($urandom)}, s);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
        end
        check_regs();
    endtask

    task automatic test_reset_mid();
        int s;
        issue(mk_imm(8'h01, 9, 0, 15'h0055), s);
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready_o, alu_valid_o, illegal_o, alu_op_o, alu_a_o, alu_b_o} !== 75'h0) begin
            bad++;
            $display("FAIL midreset_outputs: ready=%b valid=%b ill=%b op=%h a=%h b=%h required all 0",
                     in_ready_o, alu_valid_o, illegal_o, alu_op_o, alu_a_o, alu_b_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        check_regs();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ld();
        test_back_to_back();
        test_independent();
        test_illegal();
        test_r0();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
